aes_spi_host_ctrl: RTL and testbench

// - Host-side sequencer upstream of SPI_Main; SPI_Main in turn drives the AES_Encrypt SPI slave.
// - Accepts one {key, key_len, plaintext} request per valid/ready handshake.
// - Issues three SPI_Main transactions in order: key frame, message frame, all-zero readout frame.
// - Returns the 128-bit ciphertext captured from the readout frame, or an error flag.

---
 rtl/aes_spi_host_ctrl_pkg.sv | 44 ++++
 rtl/aes_spi_host_ctrl_phase_timer.sv | 28 ++
 rtl/aes_spi_host_ctrl.sv | 166 ++++++++++++++++
 tb/tb_aes_spi_host_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_host_ctrl_pkg.sv
// Shared definitions for the AES SPI host sequencer: key-size codes, frame widths,
// phase/sub-phase encodings and frame builders.
package aes_spi_host_ctrl_pkg;

  localparam int unsigned FRAME_W = 258;
  localparam int unsigned CT_W    = 128;

  localparam logic [1:0] KLEN_128 = 2'b00;
  localparam logic [1:0] KLEN_192 = 2'b01;
  localparam logic [1:0] KLEN_256 = 2'b10;
  localparam logic [1:0] KLEN_BAD = 2'b11;

  typedef enum logic [2:0] {
    PhIdle,
    PhKey,
    PhMsg,
    PhRd,
    PhResp
  } phase_e;

  typedef enum logic [1:0] {
    SubStart,
    SubWait,
    SubGap
  } sub_e;

  // Key frame: size code in bits [0:1], key right-aligned and masked to its length.
  function automatic logic [0:FRAME_W-1] key_frame(input logic [1:0]   klen,
                                                   input logic [255:0] key);
    logic [255:0] masked;
    masked = key;
    case (klen)
      KLEN_128: masked = {128'b0, key[127:0]};
      KLEN_192: masked = {64'b0, key[191:0]};
      default:  masked = key;
    endcase
    return {klen, masked};
  endfunction

  function automatic logic [0:FRAME_W-1] msg_frame(input logic [127:0] pt);
    return {2'b00, 128'b0, pt};
  endfunction

endpackage

// File: rtl/aes_spi_host_ctrl_phase_timer.sv
// Loadable down-counter with zero flag; shared by the start-hold, gap and
// done-timeout intervals. Saturates at zero.
module aes_spi_host_ctrl_phase_timer #(
  parameter int unsigned Width = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  // Reload on sub-phase entry, otherwise count down towards zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/aes_spi_host_ctrl.sv
// Host-side sequencer for the AES SPI slave: key frame, message frame, readout
// frame, then one response pulse carrying the ciphertext or an error flag.
module aes_spi_host_ctrl
  import aes_spi_host_ctrl_pkg::*;
#(
  parameter int unsigned START_HOLD   = 2,
  parameter int unsigned GAP_CYCLES   = 8,
  parameter int unsigned DONE_TIMEOUT = 4096,
  parameter logic        SLAVE_SEL    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_key_len,
  input  logic [255:0]         req_key,
  input  logic [127:0]         req_pt,
  output logic                 resp_valid,
  output logic [CT_W-1:0]      resp_ct,
  output logic                 resp_err,
  output logic                 busy,
  output logic [0:FRAME_W-1]   spi_tx,
  output logic                 spi_start,
  output logic                 spi_sel,
  input  logic                 spi_done,
  input  logic [0:CT_W-1]      spi_rx
);

  localparam int unsigned TmrW = $clog2(DONE_TIMEOUT + 1);

  phase_e         phase_q;
  sub_e           sub_q;
  logic [127:0]   pt_q;
  logic           done_prev_q;

  logic           accept, legal, active, done_rise;
  logic           start_end, wait_hit, gap_end;
  logic           tmr_load, tmr_zero;
  logic [TmrW-1:0] tmr_val;

  assign spi_sel   = SLAVE_SEL;
  assign accept    = req_valid && req_ready;
  assign legal     = (req_key_len != KLEN_BAD);
  assign active    = (phase_q == PhKey) || (phase_q == PhMsg) || (phase_q == PhRd);
  // A level already high on WAIT entry is ignored: only a 0->1 transition completes.
  assign done_rise = spi_done && !done_prev_q;
  assign start_end = active && (sub_q == SubStart) && tmr_zero;
  assign wait_hit  = active && (sub_q == SubWait) && done_rise;
  assign gap_end   = active && (sub_q == SubGap) && tmr_zero;

  // Timer reload on every sub-phase entry; mirrors the transitions in the FSM below.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (accept && legal) begin
      tmr_load = 1'b1;
      tmr_val  = TmrW'(START_HOLD - 1);
    end else if (start_end) begin
      tmr_load = 1'b1;
      tmr_val  = TmrW'(DONE_TIMEOUT);
    end else if (wait_hit && (phase_q != PhRd)) begin
      tmr_load = 1'b1;
      tmr_val  = TmrW'(GAP_CYCLES - 1);
    end else if (gap_end) begin
      tmr_load = 1'b1;
      tmr_val  = TmrW'(START_HOLD - 1);
    end
  end

  aes_spi_host_ctrl_phase_timer #(
    .Width(TmrW)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  // Sequencer FSM with registered handshake, frame and SPI outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PhIdle;
      sub_q       <= SubStart;
      pt_q        <= '0;
      done_prev_q <= 1'b0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_ct     <= '0;
      resp_err    <= 1'b0;
      busy        <= 1'b0;
      spi_start   <= 1'b0;
      spi_tx      <= '0;
    end else begin
      done_prev_q <= spi_done;
      resp_valid  <= 1'b0;
      unique case (phase_q)
        PhIdle: begin
          if (accept) begin
            pt_q      <= req_pt;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (legal) begin
              phase_q   <= PhKey;
              sub_q     <= SubStart;
              spi_start <= 1'b1;
              spi_tx    <= key_frame(req_key_len, req_key);
            end else begin
              phase_q    <= PhResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end
          end
        end
        PhKey, PhMsg, PhRd: begin
          case (sub_q)
            SubStart: begin
              if (tmr_zero) begin
                spi_start <= 1'b0;
                sub_q     <= SubWait;
              end
            end
            SubWait: begin
              if (done_rise) begin
                if (phase_q == PhRd) begin
                  resp_ct    <= spi_rx;
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  phase_q    <= PhResp;
                end else begin
                  sub_q <= SubGap;
                end
              end else if (tmr_zero) begin
                resp_err   <= 1'b1;
                resp_valid <= 1'b1;
                phase_q    <= PhResp;
              end
            end
            SubGap: begin
              if (tmr_zero) begin
                sub_q     <= SubStart;
                spi_start <= 1'b1;
                if (phase_q == PhKey) begin
                  phase_q <= PhMsg;
                  spi_tx  <= msg_frame(pt_q);
                end else begin
                  phase_q <= PhRd;
                  spi_tx  <= '0;
                end
              end
            end
            default: sub_q <= SubStart;
          endcase
        end
        PhResp: begin
          phase_q   <= PhIdle;
          sub_q     <= SubStart;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: phase_q <= PhIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_host_ctrl.sv
// Directed bench for aes_spi_host_ctrl with a behavioural SPI_Main + AES slave model
// that answers the readout frame with known ciphertexts.
module tb_aes_spi_host_ctrl;

  localparam int SPI_LAT      = 20;
  localparam int DONE_TIMEOUT = 4096;

  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CTBAD  = 128'hdeaddeaddeaddeaddeaddeaddeaddead;

  localparam logic [0:257] KF128 = {2'b00, 128'h0, KEY128};
  localparam logic [0:257] KF192 = {2'b01, 64'h0, KEY192};
  localparam logic [0:257] KF256 = {2'b10, KEY256};
  localparam logic [0:257] MF    = {2'b00, 128'h0, PT};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [1:0]     req_key_len = 2'b00;
  logic [255:0]   req_key = '0;
  logic [127:0]   req_pt = '0;
  logic           resp_valid;
  logic [127:0]   resp_ct;
  logic           resp_err;
  logic           busy;
  logic [0:257]   spi_tx;
  logic           spi_start;
  logic           spi_sel;
  logic           spi_done = 1'b0;
  logic [0:127]   spi_rx = '0;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int starts = 0;
  logic overlap = 1'b0;
  logic slave_en = 1'b1;
  logic [0:257] frm [3];

  aes_spi_host_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_key_len(req_key_len),
    .req_key    (req_key),
    .req_pt     (req_pt),
    .resp_valid (resp_valid),
    .resp_ct    (resp_ct),
    .resp_err   (resp_err),
    .busy       (busy),
    .spi_tx     (spi_tx),
    .spi_start  (spi_start),
    .spi_sel    (spi_sel),
    .spi_done   (spi_done),
    .spi_rx     (spi_rx)
  );

  always #1 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    if (resp_valid && req_ready) overlap <= 1'b1;
  end

  task automatic check(input string tag, input logic [257:0] got, input logic [257:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] lookup();
    if (frm[1] != MF || frm[2] != '0) return CTBAD;
    if (frm[0] == KF128) return CT128;
    if (frm[0] == KF192) return CT192;
    if (frm[0] == KF256) return CT256;
    return CTBAD;
  endfunction

  // Slave model: records frames per start, raises done SPI_LAT cycles after start falls.
  // The previous done level is left high into the next transaction and dropped mid-way.
  initial begin
    int seq, cur, cnt;
    logic seen, pend;
    seq = 0; cur = 0; cnt = 0; seen = 1'b0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seq = 0; seen = 1'b0; pend = 1'b0; cnt = 0; spi_done = 1'b0;
      end else begin
        if (!slave_en) spi_done = 1'b0;
        if (spi_start && !seen) begin
          seen = 1'b1;
          starts++;
          if (slave_en) begin
            frm[seq] = spi_tx;
            cur = seq;
            seq = (seq + 1) % 3;
          end
        end else if (!spi_start && seen) begin
          seen = 1'b0;
          if (slave_en) begin
            pend = 1'b1;
            cnt = SPI_LAT;
          end
        end else if (pend) begin
          if (cnt > 0) begin
            cnt--;
            if (cnt == SPI_LAT - 5) spi_done = 1'b0;
          end else begin
            pend = 1'b0;
            if (cur == 2) spi_rx = lookup();
            spi_done = 1'b1;
          end
        end
      end
    end
  end

  // Present a request and hold it until accepted; returns on the negedge after accept.
  task automatic send(input logic [1:0] klen, input logic [255:0] key, input logic [127:0] pt);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_key_len = klen; req_key = key; req_pt = pt;
    n = 0;
    while (!req_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic release_req();
    req_valid = 1'b0; req_key_len = 2'b11; req_key = '1; req_pt = '1;
  endtask

  task automatic wait_resp(input int budget, output logic [127:0] ct, output logic err,
                           output int lat);
    lat = 0;
    while (!resp_valid && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 1'b0, 1'b1);
    ct = resp_ct;
    err = resp_err;
    check("ready_low_at_resp", req_ready, 1'b0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_req_ready"}, req_ready, 1'b1);
    check({pfx, "_resp_valid"}, resp_valid, 1'b0);
    check({pfx, "_resp_ct"}, resp_ct, 128'h0);
    check({pfx, "_resp_err"}, resp_err, 1'b0);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_spi_start"}, spi_start, 1'b0);
    check({pfx, "_spi_tx"}, spi_tx, 258'h0);
  endtask

  initial begin
    logic [127:0] ct;
    logic err;
    int lat, s0, a0, n;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    check("spi_sel", spi_sel, 1'b0);
    rst = 1'b0;

    // 128-bit key with junk above bit 127 to exercise masking.
    s0 = starts;
    send(2'b00, {128'hffffffffffffffffffffffffffffffff, KEY128}, PT);
    check("busy_after_accept", busy, 1'b1);
    release_req();
    wait_resp(300, ct, err, lat);
    check("ct128", ct, CT128);
    check("err128", err, 1'b0);
    check("lat128", lat, 28 + 3 * SPI_LAT);
    check("starts128", starts - s0, 3);
    check("kf128", frm[0], KF128);
    check("mf128", frm[1], MF);
    check("rf128", frm[2], 258'h0);

    // 192-bit, then 256-bit held on req_* while busy.
    a0 = acc_cnt;
    send(2'b01, {64'hffffffffffffffff, KEY192}, PT);
    req_key_len = 2'b10; req_key = KEY256;
    wait_resp(300, ct, err, lat);
    check("ct192", ct, CT192);
    check("err192", err, 1'b0);
    check("accepts_while_busy", acc_cnt - a0, 1);
    check("kcode192", frm[0][0:1], 2'b01);
    check("kf192", frm[0], KF192);
    send(2'b10, KEY256, PT);
    release_req();
    wait_resp(300, ct, err, lat);
    check("ct256", ct, CT256);
    check("err256", err, 1'b0);
    check("accepts_b2b", acc_cnt - a0, 2);

    // Illegal key length.
    s0 = starts;
    send(2'b11, KEY256, PT);
    release_req();
    wait_resp(10, ct, err, lat);
    check("illegal_err", err, 1'b1);
    check("illegal_fast", (lat <= 3), 1'b1);
    check("illegal_ct_kept", ct, CT256);
    check("illegal_no_start", starts - s0, 0);

    // Slave disconnected: done never rises.
    slave_en = 1'b0;
    s0 = starts;
    send(2'b00, {128'h0, KEY128}, PT);
    release_req();
    wait_resp(DONE_TIMEOUT + 200, ct, err, lat);
    check("to_err", err, 1'b1);
    check("to_ct_kept", ct, CT256);
    check("to_start_low", spi_start, 1'b0);
    check("to_lat_range", (lat > DONE_TIMEOUT) && (lat < DONE_TIMEOUT + 20), 1'b1);
    check("to_one_start", starts - s0, 1);
    slave_en = 1'b1;

    send(2'b00, {128'h0, KEY128}, PT);
    release_req();
    wait_resp(300, ct, err, lat);
    check("ct128_after_to", ct, CT128);
    check("err128_after_to", err, 1'b0);

    // Reset during the message frame's WAIT.
    s0 = starts;
    send(2'b00, {128'h0, KEY128}, PT);
    release_req();
    n = 0;
    while (!(starts - s0 == 2 && !spi_start) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reached_msg_wait", (starts - s0 == 2) && !spi_start, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0;

    send(2'b00, {128'h0, KEY128}, PT);
    release_req();
    wait_resp(300, ct, err, lat);
    check("ct128_after_rst", ct, CT128);
    check("err128_after_rst", err, 1'b0);

    check("ready_resp_overlap", overlap, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
